// File: rtl/conv_stream_ctrl.sv
// Streaming sequencer for the 3x3 convolution accelerator: raster-reads the source image,
// pushes each pixel to the accelerator and writes back shifted, clamped 8-bit results.
module conv_stream_ctrl #(
  parameter int IMG_WIDTH  = 128,
  parameter int IMG_HEIGHT = 128,
  parameter int ADDR_W     = 16,
  parameter int SHIFT      = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              busy,
  output logic              done,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              acc_en,
  output logic              acc_we,
  output logic [3:0]        acc_addr,
  output logic [31:0]       acc_din,
  input  logic [31:0]       acc_dout
);
  // state   | meaning
  // IDLE    | waiting for start, all outputs low
  // CLEAR   | clear accelerator line buffers
  // RD      | memory read of pixel i
  // WAIT    | capture read data
  // PUSH    | push pixel i into accelerator
  // READ    | request result of pending pixel
  // WB      | write clamped result to destination
  // FLUSH   | push a dummy pixel to expose the last result
  // DONE    | one-cycle completion pulse

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_RD, S_WAIT, S_PUSH, S_READ, S_WB, S_FLUSH, S_DONE
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  src_addr;
  logic [ADDR_W-1:0]  dst_addr;
  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic               prev_valid;
  logic               all_pushed;
  logic               flushed;
  logic               cur_valid;
  logic               cur_last;
  logic signed [31:0] res_shifted;
  logic [7:0]         pix8;

  assign cur_valid = (row >= RW'(2)) && (col >= CW'(2));
  assign cur_last  = (row == ROW_LAST) && (col == COL_LAST);

  // acc_dout is only meaningful during WB, so the write data is gated by mem_wen
  always_comb begin
    res_shifted = $signed(acc_dout) >>> SHIFT;
    if (res_shifted < 0)               pix8 = 8'd0;
    else if (res_shifted > 32'sd255)   pix8 = 8'hff;
    else                               pix8 = res_shifted[7:0];
  end

  assign mem_wdata = mem_wen ? {24'd0, pix8} : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      src_addr   <= '0;
      dst_addr   <= '0;
      col        <= '0;
      row        <= '0;
      prev_valid <= 1'b0;
      all_pushed <= 1'b0;
      flushed    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mem_ren    <= 1'b0;
      mem_raddr  <= '0;
      mem_wen    <= 1'b0;
      mem_waddr  <= '0;
      acc_en     <= 1'b0;
      acc_we     <= 1'b0;
      acc_addr   <= 4'd0;
      acc_din    <= 32'd0;
    end else begin
      done      <= 1'b0;
      mem_ren   <= 1'b0;
      mem_raddr <= '0;
      mem_wen   <= 1'b0;
      mem_waddr <= '0;
      acc_en    <= 1'b0;
      acc_we    <= 1'b0;
      acc_addr  <= 4'd0;
      acc_din   <= 32'd0;
      case (state)
        S_IDLE: begin
          if (start) begin
            src_addr   <= src_base;
            dst_addr   <= dst_base;
            col        <= '0;
            row        <= '0;
            prev_valid <= 1'b0;
            all_pushed <= 1'b0;
            flushed    <= 1'b0;
            busy       <= 1'b1;
            state      <= S_CLEAR;
            acc_en     <= 1'b1;
            acc_we     <= 1'b1;
            acc_addr   <= 4'd2;
          end
        end
        S_CLEAR: begin
          state     <= S_RD;
          mem_ren   <= 1'b1;
          mem_raddr <= src_addr;
        end
        S_RD: state <= S_WAIT;
        S_WAIT: begin
          state    <= S_PUSH;
          acc_en   <= 1'b1;
          acc_we   <= 1'b1;
          acc_addr <= 4'd0;
          acc_din  <= mem_rdata;
        end
        S_PUSH: begin
          prev_valid <= cur_valid;
          if (cur_last) begin
            all_pushed <= 1'b1;
          end else begin
            src_addr <= src_addr + ADDR_W'(1);
            if (col == COL_LAST) begin
              col <= '0;
              row <= row + RW'(1);
            end else begin
              col <= col + CW'(1);
            end
          end
          if (prev_valid) begin
            state    <= S_READ;
            acc_en   <= 1'b1;
            acc_addr <= 4'd1;
          end else if (cur_last) begin
            state  <= S_FLUSH;
            acc_en <= 1'b1;
            acc_we <= 1'b1;
          end else begin
            state     <= S_RD;
            mem_ren   <= 1'b1;
            mem_raddr <= src_addr + ADDR_W'(1);
          end
        end
        S_READ: begin
          state     <= S_WB;
          mem_wen   <= 1'b1;
          mem_waddr <= dst_addr;
        end
        S_WB: begin
          dst_addr <= dst_addr + ADDR_W'(1);
          if (flushed) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else if (all_pushed) begin
            state  <= S_FLUSH;
            acc_en <= 1'b1;
            acc_we <= 1'b1;
          end else begin
            state     <= S_RD;
            mem_ren   <= 1'b1;
            mem_raddr <= src_addr;
          end
        end
        S_FLUSH: begin
          flushed  <= 1'b1;
          state    <= S_READ;
          acc_en   <= 1'b1;
          acc_addr <= 4'd1;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
